i2s_receiver_tdm: RTL and testbench

Parametrised serial-audio receiver: deserialises I2S (one-bit delay) or left-justified stereo, or TDM frames of up to 16 slots, into per-slot parallel samples tagged with a channel index and qualified by a one-cycle strobe. It sits at the audio input of the synth, between the external ADC/codec pins and the sample-processing pipeline. Compared with the plain stereo receiver, it adds:
- selectable framing mode;
- independent slot and sample widths;
- multi-channel TDM;
- a valid strobe;
- frame-sync lock and error detection.

---
 rtl/i2s_receiver_tdm.sv | 151 +++++++++++++++
 tb/tb_i2s_receiver_tdm.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_receiver_tdm.sv
`default_nettype none
// ============================================================================
// Module   : i2s_receiver_tdm
// Purpose  : I2S / left-justified stereo or TDM serial-audio deserialiser
//            with per-slot sample strobe, frame lock and sync-error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_receiver_tdm #(
  parameter int AudioWidth = 16,
  parameter int SlotWidth  = 32,
  parameter int Channels   = 2,
  parameter int Mode       = 0,
  parameter int ChWidth    = $clog2(Channels)
) (
  input  logic                  SCLK,
  input  logic                  RESET,
  input  logic                  LRCLK,
  input  logic                  SD,
  output logic [AudioWidth-1:0] SampleData,
  output logic [ChWidth-1:0]    SampleCh,
  output logic                  SampleValid,
  output logic                  Locked,
  output logic                  SyncError
);

  localparam bit c_STEREO  = (Channels == 2);
  localparam int c_CNT_MAX = (SlotWidth > AudioWidth) ? SlotWidth : AudioWidth;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
  localparam int c_FRAME   = Channels * SlotWidth;
  localparam int c_GAP_MAX = (c_FRAME > AudioWidth) ? c_FRAME : AudioWidth;
  localparam int c_GAP_W   = $clog2(c_GAP_MAX + 1) + 1;

  localparam logic [c_CNT_W-1:0] c_AW_CNT    = c_CNT_W'(AudioWidth);
  localparam logic [c_CNT_W-1:0] c_LSB_CNT   = c_CNT_W'(AudioWidth - 1);
  localparam logic [c_CNT_W-1:0] c_SLOT_END  = c_CNT_W'(SlotWidth - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
  localparam logic [c_GAP_W-1:0] c_AW_GAP    = c_GAP_W'(AudioWidth);
  localparam logic [c_GAP_W-1:0] c_FRAME_GAP = c_GAP_W'(c_FRAME);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE   = c_GAP_W'(1);
  localparam logic [ChWidth-1:0] c_LAST_SLOT = ChWidth'(Channels - 1);
  localparam logic [ChWidth-1:0] c_SLOT_ONE  = ChWidth'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                r_state, w_state_n;
  logic                  r_lr_q;
  logic [c_CNT_W-1:0]    r_cnt, w_cnt_n;
  logic [c_GAP_W-1:0]    r_gap, w_gap_n;
  logic [ChWidth-1:0]    r_slot, w_slot_n;
  logic [AudioWidth-2:0] r_shift, w_shift_n;
  logic [AudioWidth-1:0] w_data_n;
  logic [ChWidth-1:0]    w_ch_n;
  logic                  w_valid_n, w_locked_n, w_err_n;

  logic                  w_edge, w_rise, w_start, w_err, w_old_bit;
  logic [AudioWidth-1:0] w_shift_in;

  assign w_edge     = (LRCLK != r_lr_q);
  assign w_rise     = w_edge & LRCLK;
  assign w_start    = c_STEREO ? w_edge : w_rise;
  assign w_err      = Locked & (c_STEREO ? (r_gap < c_AW_GAP) : (r_gap != c_FRAME_GAP));
  assign w_shift_in = {r_shift, SD};
  // In left-justified mode the start-cycle bit is the new slot's MSB, not the old slot's tail
  assign w_old_bit  = (r_state == ST_RUN) && !((Mode != 0) && w_start);

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_slot_n   = r_slot;
    w_shift_n  = r_shift;
    w_data_n   = SampleData;
    w_ch_n     = SampleCh;
    w_valid_n  = 1'b0;
    w_err_n    = 1'b0;
    w_locked_n = Locked;
    w_gap_n    = (r_gap == '1) ? r_gap : r_gap + c_GAP_ONE;

    if (w_old_bit) begin
      if (r_cnt < c_AW_CNT) begin
        w_shift_n = w_shift_in[AudioWidth-2:0];
      end
      if (r_cnt == c_LSB_CNT) begin
        w_data_n  = w_shift_in;
        w_ch_n    = r_slot;
        w_valid_n = 1'b1;
      end
      if (c_STEREO) begin
        if (r_cnt < c_AW_CNT) begin
          w_cnt_n = r_cnt + c_CNT_ONE;
        end
      end else if (r_cnt == c_SLOT_END) begin
        w_cnt_n = '0;
        if (r_slot == c_LAST_SLOT) begin
          w_state_n = ST_IDLE;
        end else begin
          w_slot_n = r_slot + c_SLOT_ONE;
        end
      end else begin
        w_cnt_n = r_cnt + c_CNT_ONE;
      end
    end

    // A slot start overrides any partial sample in flight
    if (w_start) begin
      w_state_n  = ST_RUN;
      w_locked_n = 1'b1;
      w_gap_n    = c_GAP_ONE;
      w_err_n    = w_err;
      w_slot_n   = c_STEREO ? ChWidth'(LRCLK) : '0;
      if (Mode == 0) begin
        w_cnt_n = '0;
      end else begin
        w_shift_n = w_shift_in[AudioWidth-2:0];
        w_cnt_n   = c_CNT_ONE;
      end
    end
  end

  always_ff @(posedge SCLK or posedge RESET) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_lr_q      <= 1'b0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_slot      <= '0;
      r_shift     <= '0;
      SampleData  <= '0;
      SampleCh    <= '0;
      SampleValid <= 1'b0;
      Locked      <= 1'b0;
      SyncError   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_lr_q      <= LRCLK;
      r_cnt       <= w_cnt_n;
      r_gap       <= w_gap_n;
      r_slot      <= w_slot_n;
      r_shift     <= w_shift_n;
      SampleData  <= w_data_n;
      SampleCh    <= w_ch_n;
      SampleValid <= w_valid_n;
      Locked      <= w_locked_n;
      SyncError   <= w_err_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2s_receiver_tdm.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_receiver_tdm
// Purpose  : Directed self-checking bench for i2s_receiver_tdm (stereo I2S,
//            stereo left-justified and 8-slot TDM instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_receiver_tdm;

  logic        SCLK = 1'b0;
  logic        RESET;
  logic        lr_s0, sd_s0, lr_s1, sd_s1, lr_t, sd_t;
  logic [15:0] data_s0, data_s1;
  logic        ch_s0, ch_s1;
  logic        val_s0, val_s1, lock_sig_s0, lock_sig_s1, serr_s0, serr_s1;
  logic [23:0] data_t;
  logic [2:0]  ch_t;
  logic        val_t, lock_sig_t, serr_t;

  typedef struct {
    int cyc;
    int ch;
    int data;
  } ev_t;

  ev_t q_s0[$];
  ev_t q_s1[$];
  ev_t q_t[$];
  int  eq_s0[$];
  int  eq_s1[$];
  int  eq_t[$];
  int  lock_s0 = -1, lock_s1 = -1, lock_t = -1;
  logic pl_s0 = 1'b0, pl_s1 = 1'b0, pl_t = 1'b0;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;

  i2s_receiver_tdm #(.AudioWidth(16), .SlotWidth(32), .Channels(2), .Mode(0)) dut_s0 (
    .SCLK(SCLK), .RESET(RESET), .LRCLK(lr_s0), .SD(sd_s0),
    .SampleData(data_s0), .SampleCh(ch_s0), .SampleValid(val_s0),
    .Locked(lock_sig_s0), .SyncError(serr_s0));

  i2s_receiver_tdm #(.AudioWidth(16), .SlotWidth(32), .Channels(2), .Mode(1)) dut_s1 (
    .SCLK(SCLK), .RESET(RESET), .LRCLK(lr_s1), .SD(sd_s1),
    .SampleData(data_s1), .SampleCh(ch_s1), .SampleValid(val_s1),
    .Locked(lock_sig_s1), .SyncError(serr_s1));

  i2s_receiver_tdm #(.AudioWidth(24), .SlotWidth(32), .Channels(8), .Mode(0)) dut_t (
    .SCLK(SCLK), .RESET(RESET), .LRCLK(lr_t), .SD(sd_t),
    .SampleData(data_t), .SampleCh(ch_t), .SampleValid(val_t),
    .Locked(lock_sig_t), .SyncError(serr_t));

  always #5 SCLK = ~SCLK;

  // Event log: cyc is the index of the posedge that registered the output
  always @(posedge SCLK) begin
    ev_t e;
    cyc = cyc + 1;
    #1;
    if (val_s0) begin e.cyc = cyc; e.ch = int'(ch_s0); e.data = int'(data_s0); q_s0.push_back(e); end
    if (val_s1) begin e.cyc = cyc; e.ch = int'(ch_s1); e.data = int'(data_s1); q_s1.push_back(e); end
    if (val_t)  begin e.cyc = cyc; e.ch = int'(ch_t);  e.data = int'(data_t);  q_t.push_back(e);  end
    if (serr_s0) eq_s0.push_back(cyc);
    if (serr_s1) eq_s1.push_back(cyc);
    if (serr_t)  eq_t.push_back(cyc);
    if (lock_sig_s0 && !pl_s0) lock_s0 = cyc;
    if (lock_sig_s1 && !pl_s1) lock_s1 = cyc;
    if (lock_sig_t  && !pl_t)  lock_t  = cyc;
    pl_s0 = lock_sig_s0;
    pl_s1 = lock_sig_s1;
    pl_t  = lock_sig_t;
  end

  task automatic idle(input int k);
    repeat (k) @(negedge SCLK);
  endtask

  // One stereo half-frame on both stereo DUTs; n = posedge index of its LRCLK edge
  task automatic stereo_half(input logic lr, input logic [15:0] d, input int len, output int n);
    n = 0;
    for (int j = 0; j < len; j++) begin
      @(negedge SCLK);
      if (j == 0) n = cyc + 1;
      lr_s0 = lr;
      lr_s1 = lr;
      sd_s0 = (j >= 1 && j <= 16) ? d[16-j] : 1'b0;
      sd_s1 = (j < 16) ? d[15-j] : 1'b0;
    end
  endtask

  // One TDM frame (I2S timing); slot s carries base+s
  task automatic tdm_frame(input int base, input int len, output int n);
    logic [23:0] v;
    n = 0;
    for (int j = 0; j < len; j++) begin
      @(negedge SCLK);
      if (j == 0) n = cyc + 1;
      lr_t = (j < 16);
      sd_t = 1'b0;
      if (j >= 1 && (j - 1) / 32 < 8 && (j - 1) % 32 < 24) begin
        v    = 24'(base + (j - 1) / 32);
        sd_t = v[23 - (j - 1) % 32];
      end
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    lr_s0 = 1'b0; sd_s0 = 1'b0; lr_s1 = 1'b0; sd_s1 = 1'b0; lr_t = 1'b0; sd_t = 1'b0;
    idle(3);
    #1;
    n_checks++; if ({data_s0, ch_s0, val_s0, lock_sig_s0, serr_s0} !== 20'h0) $display("FAIL reset_s0: got data %h ch %0d v %0d l %0d e %0d want all 0", data_s0, ch_s0, val_s0, lock_sig_s0, serr_s0); else n_pass++;
    n_checks++; if ({data_s1, ch_s1, val_s1, lock_sig_s1, serr_s1} !== 20'h0) $display("FAIL reset_s1: got data %h ch %0d v %0d l %0d e %0d want all 0", data_s1, ch_s1, val_s1, lock_sig_s1, serr_s1); else n_pass++;
    n_checks++; if ({data_t, ch_t, val_t, lock_sig_t, serr_t} !== 30'h0) $display("FAIL reset_t: got data %h ch %0d v %0d l %0d e %0d want all 0", data_t, ch_t, val_t, lock_sig_t, serr_t); else n_pass++;
    @(negedge SCLK);
    RESET = 1'b0;
    idle(4);
    n_checks++; if ({lock_sig_s0, lock_sig_s1, lock_sig_t} !== 3'b000) $display("FAIL reset_nolock: got %b want 000", {lock_sig_s0, lock_sig_s1, lock_sig_t}); else n_pass++;
  endtask

  task automatic test_stereo();
    int b0, b1, e0, e1, na, nb, nc;
    int ech[3];
    int ed[3];
    int ec[3];
    b0 = q_s0.size(); b1 = q_s1.size(); e0 = eq_s0.size(); e1 = eq_s1.size();
    stereo_half(1'b1, 16'h8001, 32, na);
    stereo_half(1'b0, 16'hA5C3, 32, nb);
    stereo_half(1'b1, 16'h1234, 32, nc);
    idle(4);
    ech = '{1, 0, 1};
    ed  = '{32'h8001, 32'hA5C3, 32'h1234};
    ec  = '{na + 16, nb + 16, nc + 16};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (b0 + i >= q_s0.size()) $display("FAIL stereo_i2s_ev%0d: got none want cyc %0d ch %0d data %h", i, ec[i], ech[i], ed[i]);
      else if (q_s0[b0+i].cyc !== ec[i] || q_s0[b0+i].ch !== ech[i] || q_s0[b0+i].data !== ed[i])
        $display("FAIL stereo_i2s_ev%0d: got cyc %0d ch %0d data %h want cyc %0d ch %0d data %h", i, q_s0[b0+i].cyc, q_s0[b0+i].ch, q_s0[b0+i].data, ec[i], ech[i], ed[i]);
      else n_pass++;
      n_checks++;
      if (b1 + i >= q_s1.size()) $display("FAIL stereo_lj_ev%0d: got none want cyc %0d ch %0d data %h", i, ec[i] - 1, ech[i], ed[i]);
      else if (q_s1[b1+i].cyc !== ec[i] - 1 || q_s1[b1+i].ch !== ech[i] || q_s1[b1+i].data !== ed[i])
        $display("FAIL stereo_lj_ev%0d: got cyc %0d ch %0d data %h want cyc %0d ch %0d data %h", i, q_s1[b1+i].cyc, q_s1[b1+i].ch, q_s1[b1+i].data, ec[i] - 1, ech[i], ed[i]);
      else n_pass++;
    end
    n_checks++; if (q_s0.size() - b0 !== 3) $display("FAIL stereo_i2s_count: got %0d want 3", q_s0.size() - b0); else n_pass++;
    n_checks++; if (q_s1.size() - b1 !== 3) $display("FAIL stereo_lj_count: got %0d want 3", q_s1.size() - b1); else n_pass++;
    n_checks++; if (lock_s0 !== na) $display("FAIL stereo_i2s_lock_cyc: got %0d want %0d", lock_s0, na); else n_pass++;
    n_checks++; if (lock_s1 !== na) $display("FAIL stereo_lj_lock_cyc: got %0d want %0d", lock_s1, na); else n_pass++;
    n_checks++; if (eq_s0.size() - e0 + eq_s1.size() - e1 !== 0) $display("FAIL stereo_no_syncerr: got %0d want 0", eq_s0.size() - e0 + eq_s1.size() - e1); else n_pass++;
    n_checks++; if ({lock_sig_s0, lock_sig_s1} !== 2'b11) $display("FAIL stereo_locked: got %b want 11", {lock_sig_s0, lock_sig_s1}); else n_pass++;
  endtask

  task automatic test_short_slot();
    int b0, b1, e0, e1, n1, n2, n3;
    b0 = q_s0.size(); b1 = q_s1.size(); e0 = eq_s0.size(); e1 = eq_s1.size();
    stereo_half(1'b0, 16'h5555, 32, n1);
    stereo_half(1'b1, 16'h7777, 10, n2);
    stereo_half(1'b0, 16'h9ABC, 32, n3);
    idle(2);
    n_checks++; if (q_s0.size() - b0 !== 2) $display("FAIL short_i2s_count: got %0d want 2", q_s0.size() - b0);
    else if (q_s0[b0].cyc !== n1 + 16 || q_s0[b0].data !== 32'h5555 || q_s0[b0+1].cyc !== n3 + 16 || q_s0[b0+1].ch !== 0 || q_s0[b0+1].data !== 32'h9ABC)
      $display("FAIL short_i2s_data: got %0d/%h %0d/%0d/%h want %0d/5555 %0d/0/9abc", q_s0[b0].cyc, q_s0[b0].data, q_s0[b0+1].cyc, q_s0[b0+1].ch, q_s0[b0+1].data, n1 + 16, n3 + 16);
    else n_pass++;
    n_checks++; if (q_s1.size() - b1 !== 2) $display("FAIL short_lj_count: got %0d want 2", q_s1.size() - b1);
    else if (q_s1[b1].cyc !== n1 + 15 || q_s1[b1].data !== 32'h5555 || q_s1[b1+1].cyc !== n3 + 15 || q_s1[b1+1].ch !== 0 || q_s1[b1+1].data !== 32'h9ABC)
      $display("FAIL short_lj_data: got %0d/%h %0d/%0d/%h want %0d/5555 %0d/0/9abc", q_s1[b1].cyc, q_s1[b1].data, q_s1[b1+1].cyc, q_s1[b1+1].ch, q_s1[b1+1].data, n1 + 15, n3 + 15);
    else n_pass++;
    n_checks++; if (eq_s0.size() - e0 !== 1) $display("FAIL short_i2s_syncerr: got %0d pulses want 1 at %0d", eq_s0.size() - e0, n3);
    else if (eq_s0[e0] !== n3) $display("FAIL short_i2s_syncerr: got cyc %0d want %0d", eq_s0[e0], n3); else n_pass++;
    n_checks++; if (eq_s1.size() - e1 !== 1) $display("FAIL short_lj_syncerr: got %0d pulses want 1 at %0d", eq_s1.size() - e1, n3);
    else if (eq_s1[e1] !== n3) $display("FAIL short_lj_syncerr: got cyc %0d want %0d", eq_s1[e1], n3); else n_pass++;
    n_checks++; if ({lock_sig_s0, lock_sig_s1} !== 2'b11) $display("FAIL short_locked: got %b want 11", {lock_sig_s0, lock_sig_s1}); else n_pass++;
  endtask

  task automatic test_tdm();
    int bt, et, idx, ec, ed;
    int nf[4];
    int bf[4];
    int lens[4];
    bt = q_t.size(); et = eq_t.size();
    bf   = '{32'h000001, 32'hABCD00, 32'h000100, 32'h5A5A50};
    lens = '{256, 256, 260, 256};
    for (int f = 0; f < 4; f++) tdm_frame(bf[f], lens[f], nf[f]);
    idle(4);
    for (int f = 0; f < 4; f++) begin
      for (int s = 0; s < 8; s++) begin
        idx = bt + f * 8 + s;
        ec  = nf[f] + 24 + 32 * s;
        ed  = bf[f] + s;
        n_checks++;
        if (idx >= q_t.size()) $display("FAIL tdm_f%0d_s%0d: got none want cyc %0d ch %0d data %h", f, s, ec, s, ed);
        else if (q_t[idx].cyc !== ec || q_t[idx].ch !== s || q_t[idx].data !== ed)
          $display("FAIL tdm_f%0d_s%0d: got cyc %0d ch %0d data %h want cyc %0d ch %0d data %h", f, s, q_t[idx].cyc, q_t[idx].ch, q_t[idx].data, ec, s, ed);
        else n_pass++;
      end
    end
    n_checks++; if (q_t.size() - bt !== 32) $display("FAIL tdm_count: got %0d want 32", q_t.size() - bt); else n_pass++;
    n_checks++; if (lock_t !== nf[0]) $display("FAIL tdm_lock_cyc: got %0d want %0d", lock_t, nf[0]); else n_pass++;
    n_checks++; if (eq_t.size() - et !== 1) $display("FAIL tdm_syncerr: got %0d pulses want 1 at %0d", eq_t.size() - et, nf[3]);
    else if (eq_t[et] !== nf[3]) $display("FAIL tdm_syncerr: got cyc %0d want %0d", eq_t[et], nf[3]); else n_pass++;
    n_checks++; if (lock_sig_t !== 1'b1) $display("FAIL tdm_locked: got %0d want 1", lock_sig_t); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int b0, b1, bt, e0, e1, et, n, nt, dummy;
    tdm_frame(32'h444440, 40, dummy);
    stereo_half(1'b1, 16'hFFFF, 8, dummy);
    RESET = 1'b1;
    #1;
    n_checks++; if ({data_s0, ch_s0, val_s0, lock_sig_s0, serr_s0} !== 20'h0) $display("FAIL rstmid_s0: got data %h ch %0d v %0d l %0d e %0d want all 0", data_s0, ch_s0, val_s0, lock_sig_s0, serr_s0); else n_pass++;
    n_checks++; if ({data_s1, ch_s1, val_s1, lock_sig_s1, serr_s1} !== 20'h0) $display("FAIL rstmid_s1: got data %h ch %0d v %0d l %0d e %0d want all 0", data_s1, ch_s1, val_s1, lock_sig_s1, serr_s1); else n_pass++;
    n_checks++; if ({data_t, ch_t, val_t, lock_sig_t, serr_t} !== 30'h0) $display("FAIL rstmid_t: got data %h ch %0d v %0d l %0d e %0d want all 0", data_t, ch_t, val_t, lock_sig_t, serr_t); else n_pass++;
    lr_s0 = 1'b0; lr_s1 = 1'b0; lr_t = 1'b0; sd_s0 = 1'b1; sd_s1 = 1'b1; sd_t = 1'b1;
    idle(3);
    b0 = q_s0.size(); b1 = q_s1.size(); bt = q_t.size();
    e0 = eq_s0.size(); e1 = eq_s1.size(); et = eq_t.size();
    RESET = 1'b0;
    idle(20);
    n_checks++; if ({lock_sig_s0, lock_sig_s1, lock_sig_t} !== 3'b000) $display("FAIL rstmid_nolock: got %b want 000", {lock_sig_s0, lock_sig_s1, lock_sig_t}); else n_pass++;
    n_checks++; if (q_s0.size() - b0 + q_s1.size() - b1 + q_t.size() - bt !== 0) $display("FAIL rstmid_nostrobe: got %0d strobes want 0", q_s0.size() - b0 + q_s1.size() - b1 + q_t.size() - bt); else n_pass++;
    stereo_half(1'b1, 16'h3C5A, 32, n);
    tdm_frame(32'h777770, 40, nt);
    idle(2);
    n_checks++; if (q_s0.size() - b0 !== 1) $display("FAIL rstmid_i2s_count: got %0d want 1", q_s0.size() - b0);
    else if (q_s0[b0].cyc !== n + 16 || q_s0[b0].ch !== 1 || q_s0[b0].data !== 32'h3C5A)
      $display("FAIL rstmid_i2s_data: got cyc %0d ch %0d data %h want cyc %0d ch 1 data 3c5a", q_s0[b0].cyc, q_s0[b0].ch, q_s0[b0].data, n + 16);
    else n_pass++;
    n_checks++; if (q_s1.size() - b1 !== 1) $display("FAIL rstmid_lj_count: got %0d want 1", q_s1.size() - b1);
    else if (q_s1[b1].cyc !== n + 15 || q_s1[b1].ch !== 1 || q_s1[b1].data !== 32'h3C5A)
      $display("FAIL rstmid_lj_data: got cyc %0d ch %0d data %h want cyc %0d ch 1 data 3c5a", q_s1[b1].cyc, q_s1[b1].ch, q_s1[b1].data, n + 15);
    else n_pass++;
    n_checks++; if (q_t.size() - bt < 1) $display("FAIL rstmid_tdm: got none want cyc %0d ch 0 data 777770", nt + 24);
    else if (q_t[bt].cyc !== nt + 24 || q_t[bt].ch !== 0 || q_t[bt].data !== 32'h777770)
      $display("FAIL rstmid_tdm: got cyc %0d ch %0d data %h want cyc %0d ch 0 data 777770", q_t[bt].cyc, q_t[bt].ch, q_t[bt].data, nt + 24);
    else n_pass++;
    n_checks++; if (lock_s0 !== n || lock_t !== nt) $display("FAIL rstmid_lock_cyc: got %0d/%0d want %0d/%0d", lock_s0, lock_t, n, nt); else n_pass++;
    n_checks++; if (eq_s0.size() - e0 + eq_s1.size() - e1 + eq_t.size() - et !== 0) $display("FAIL rstmid_no_syncerr: got %0d want 0", eq_s0.size() - e0 + eq_s1.size() - e1 + eq_t.size() - et); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stereo();
    test_short_slot();
    test_tdm();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
